// File: rtl/uart_rx_out_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_out_fifo
//   Output buffer for the UART receiver. Every error-free byte that the
//   receiver strobes on rx_data_valid is written into a small synchronous FIFO
//   and offered to the system side over a valid/ready handshake. A byte that
//   arrives while the FIFO is full (and no pop frees a slot in the same cycle)
//   is dropped and the sticky overrun flag is raised. Optional saturating
//   parity / stop error frame counters are built when the macro
//   UART_RX_ERR_CNT_EN is defined; otherwise they read as constant zero.
//
// Ports
//   CLK            block clock (receiver clock domain)
//   RST            synchronous active-low reset
//   rx_p_data      received byte, valid with rx_data_valid
//   rx_data_valid  one-cycle strobe: good frame, push rx_p_data
//   rx_frame_end   one-cycle strobe: error-check cycle of every frame
//   rx_par_err     parity error flag, qualified by rx_frame_end
//   rx_stp_err     stop-bit error flag, qualified by rx_frame_end
//   m_data         head-of-FIFO byte (0 while empty)
//   m_valid        FIFO not empty
//   m_ready        consumer accepts m_data when m_valid && m_ready
//   fifo_count     occupancy, 0..FIFO_DEPTH
//   fifo_full      fifo_count == FIFO_DEPTH
//   overrun        sticky: a byte was dropped
//   clr_status     pulse: clears overrun and the error counters
//   par_err_cnt    saturating parity-error frame count
//   stp_err_cnt    saturating stop-error frame count
//
// Build option
//   UART_RX_ERR_CNT_EN  enables the error frame counters
// -----------------------------------------------------------------------------
module uart_rx_out_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_p_data,
  input  logic                  rx_data_valid,
  input  logic                  rx_frame_end,
  input  logic                  rx_par_err,
  input  logic                  rx_stp_err,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  output logic                  fifo_full,
  output logic                  overrun,
  input  logic                  clr_status,
  output logic [7:0]            par_err_cnt,
  output logic [7:0]            stp_err_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ERR_W = 8;

  // Storage and registered state
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_valid;
  logic                  r_full;
  logic                  r_overrun;
  logic [DATA_WIDTH-1:0] r_m_data;

  // Next-state wires
  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_drop;
  logic [PTR_W-1:0]      w_wr_next;
  logic [PTR_W-1:0]      w_rd_next;
  logic [CNT_WIDTH-1:0]  w_count_next;
  logic [DATA_WIDTH-1:0] w_head_next;

  // Handshake decode; a pop in a full cycle frees the slot for the push
  assign w_pop     = r_valid & m_ready;
  assign w_push_ok = rx_data_valid & (~r_full | w_pop);
  assign w_drop    = rx_data_valid & r_full & ~w_pop;

  assign w_wr_next = w_push_ok ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
  assign w_rd_next = w_pop     ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

  // Occupancy update
  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop})
      2'b10:   w_count_next = r_count + CNT_WIDTH'(1);
      2'b01:   w_count_next = r_count - CNT_WIDTH'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Next head byte. When the new head slot is the one being written this
  // cycle (push into empty, or push+pop at occupancy 1) it is bypassed from
  // rx_p_data, since the memory write lands only at the edge.
  always_comb begin
    w_head_next = '0;
    if (w_count_next == '0) begin
      w_head_next = '0;
    end else if (w_push_ok && (r_wr_ptr == w_rd_next)) begin
      w_head_next = rx_p_data;
    end else begin
      w_head_next = r_mem[w_rd_next];
    end
  end

  // Pointer, status and output registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_full    <= 1'b0;
      r_m_data  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_valid  <= (w_count_next != '0);
      r_full   <= (w_count_next == CNT_WIDTH'(FIFO_DEPTH));
      r_m_data <= w_head_next;
      // A new drop wins over a same-cycle clear
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_status) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // FIFO storage; not reset, contents are only visible through r_m_data
  always_ff @(posedge CLK) begin
    if (RST && w_push_ok) begin
      r_mem[r_wr_ptr] <= rx_p_data;
    end
  end

  assign m_data     = r_m_data;
  assign m_valid    = r_valid;
  assign fifo_count = r_count;
  assign fifo_full  = r_full;
  assign overrun    = r_overrun;

`ifdef UART_RX_ERR_CNT_EN
  logic [ERR_W-1:0] r_par_cnt;
  logic [ERR_W-1:0] r_stp_cnt;

  // Saturating error frame counters; clear wins over a same-cycle increment
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_par_cnt <= '0;
      r_stp_cnt <= '0;
    end else if (clr_status) begin
      r_par_cnt <= '0;
      r_stp_cnt <= '0;
    end else if (rx_frame_end) begin
      if (rx_par_err && (r_par_cnt != {ERR_W{1'b1}})) begin
        r_par_cnt <= r_par_cnt + ERR_W'(1);
      end
      if (rx_stp_err && (r_stp_cnt != {ERR_W{1'b1}})) begin
        r_stp_cnt <= r_stp_cnt + ERR_W'(1);
      end
    end
  end

  assign par_err_cnt = r_par_cnt;
  assign stp_err_cnt = r_stp_cnt;
`else
  // Counters absent: ports kept for a fixed interface, error inputs unused
  logic w_unused_err;
  assign w_unused_err = rx_frame_end ^ rx_par_err ^ rx_stp_err;
  assign par_err_cnt  = '0;
  assign stp_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_uart_rx_out_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_out_fifo
//   Directed test-plan steps followed by a randomized phase, with every cycle
//   compared against a queue-based reference model of the output buffer.
// -----------------------------------------------------------------------------
module tb_uart_rx_out_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] rx_p_data = '0;
  logic          rx_data_valid = 1'b0;
  logic          rx_frame_end = 1'b0;
  logic          rx_par_err = 1'b0;
  logic          rx_stp_err = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          overrun;
  logic          clr_status = 1'b0;
  logic [7:0]    par_err_cnt;
  logic [7:0]    stp_err_cnt;

  uart_rx_out_fifo #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .rx_p_data     (rx_p_data),
    .rx_data_valid (rx_data_valid),
    .rx_frame_end  (rx_frame_end),
    .rx_par_err    (rx_par_err),
    .rx_stp_err    (rx_stp_err),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .fifo_count    (fifo_count),
    .fifo_full     (fifo_full),
    .overrun       (overrun),
    .clr_status    (clr_status),
    .par_err_cnt   (par_err_cnt),
    .stp_err_cnt   (stp_err_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic       m_ovr = 1'b0;
  int         m_par = 0;
  int         m_stp = 0;
  logic [7:0] last_popped = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] head;
    head = (mq.size() != 0) ? mq[0] : 8'h00;
    chk({tag, " m_valid"},    32'(m_valid),     32'(mq.size() != 0));
    chk({tag, " m_data"},     32'(m_data),      32'(head));
    chk({tag, " fifo_count"}, 32'(fifo_count),  32'(mq.size()));
    chk({tag, " fifo_full"},  32'(fifo_full),   32'(mq.size() == DEPTH));
    chk({tag, " overrun"},    32'(overrun),     32'(m_ovr));
    chk({tag, " par_err_cnt"}, 32'(par_err_cnt), 32'(m_par));
    chk({tag, " stp_err_cnt"}, 32'(stp_err_cnt), 32'(m_stp));
  endtask

  // One clock cycle: drive inputs, advance the model, then compare after the edge
  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy,
                     input logic fe, input logic pe, input logic se,
                     input logic clr, input string tag);
    logic pop;
    logic drop;
    rx_data_valid = v;
    rx_p_data     = d;
    m_ready       = rdy;
    rx_frame_end  = fe;
    rx_par_err    = pe;
    rx_stp_err    = se;
    clr_status    = clr;
    pop  = (mq.size() != 0) && rdy;
    drop = v && (mq.size() == DEPTH) && !pop;
    if (pop) last_popped = mq.pop_front();
    if (v && !drop) mq.push_back(d);
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
`ifdef UART_RX_ERR_CNT_EN
    if (clr) begin
      m_par = 0;
      m_stp = 0;
    end else if (fe) begin
      if (pe && m_par < 255) m_par++;
      if (se && m_stp < 255) m_stp++;
    end
`endif
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  // Reset cycle, optionally with a push strobe that must be discarded
  task automatic rst_cyc(input logic v, input logic [7:0] d, input string tag);
    RST           = 1'b0;
    rx_data_valid = v;
    rx_p_data     = d;
    m_ready       = 1'b0;
    rx_frame_end  = 1'b0;
    rx_par_err    = 1'b0;
    rx_stp_err    = 1'b0;
    clr_status    = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
    m_par = 0;
    m_stp = 0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    rx_data_valid = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] seen;
    int exp_par;
    int exp_stp;

    // Reset state
    rst_cyc(1'b0, 8'h00, "reset");
    rst_cyc(1'b0, 8'h00, "reset2");

    // Single byte latency and pop
    cyc(1, 8'hA5, 0, 0, 0, 0, 0, "push_a5");
    chk("tp1 m_data", 32'(m_data), 32'h0000_00A5);
    cyc(0, 8'h00, 1, 0, 0, 0, 0, "pop_a5");
    chk("tp1 empty count", 32'(fifo_count), 32'd0);

    // Fill, overrun, drain in order, clear
    for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 0, 0, 0, 0, 0, "fill");
    chk("tp2 full", 32'(fifo_full), 32'd1);
    cyc(1, 8'h09, 0, 0, 0, 0, 0, "overrun_push");
    chk("tp2 overrun", 32'(overrun), 32'd1);
    chk("tp2 count8", 32'(fifo_count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      seen = m_data;
      chk("tp2 drain order", 32'(seen), 32'(i));
      cyc(0, 8'h00, 1, 0, 0, 0, 0, "drain");
    end
    cyc(0, 8'h00, 0, 0, 0, 0, 1, "clr_overrun");
    chk("tp2 overrun cleared", 32'(overrun), 32'd0);

    // Push into full FIFO with same-cycle pop
    for (int i = 0; i < 8; i++) cyc(1, 8'h10 + 8'(i), 0, 0, 0, 0, 0, "fill2");
    cyc(1, 8'h55, 1, 0, 0, 0, 0, "full_push_pop");
    chk("tp3 no overrun", 32'(overrun), 32'd0);
    chk("tp3 count8", 32'(fifo_count), 32'd8);
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0, 0, 0, 0, "drain2");
    chk("tp3 last byte", 32'(last_popped), 32'h0000_0055);

    // Steady push+pop across pointer wrap
    cyc(1, 8'hC0, 0, 0, 0, 0, 0, "steady_prime");
    for (int i = 1; i <= 20; i++) cyc(1, 8'hC0 + 8'(i), 1, 0, 0, 0, 0, "steady");
    chk("tp4 count1", 32'(fifo_count), 32'd1);
    cyc(0, 8'h00, 1, 0, 0, 0, 0, "steady_drain");

    // Error frame counting
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 1, 1, 0, 0, "par_err");
    for (int i = 0; i < 2; i++) cyc(0, 8'h00, 0, 1, 0, 1, 0, "stp_err");
    cyc(0, 8'h00, 0, 1, 1, 1, 0, "both_err");
    cyc(0, 8'h00, 0, 0, 1, 1, 0, "err_unqualified");
`ifdef UART_RX_ERR_CNT_EN
    exp_par = 4;
    exp_stp = 3;
`else
    exp_par = 0;
    exp_stp = 0;
`endif
    chk("tp5 par_cnt", 32'(par_err_cnt), 32'(exp_par));
    chk("tp5 stp_cnt", 32'(stp_err_cnt), 32'(exp_stp));
    chk("tp5 no push", 32'(m_valid), 32'd0);
    for (int i = 0; i < 300; i++) cyc(0, 8'h00, 0, 1, 1, 0, 0, "par_sat");
`ifdef UART_RX_ERR_CNT_EN
    exp_par = 255;
`endif
    chk("tp5 par saturate", 32'(par_err_cnt), 32'(exp_par));
    cyc(0, 8'h00, 0, 1, 1, 1, 1, "clr_vs_inc");

    // Clear and new overrun in the same cycle: set wins
    for (int i = 0; i < 8; i++) cyc(1, 8'h30 + 8'(i), 0, 0, 0, 0, 0, "fill3");
    cyc(1, 8'hEE, 0, 0, 0, 0, 1, "clr_vs_drop");
    chk("clr_vs_drop overrun", 32'(overrun), 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0, 0, 0, 0, "part_drain");

    // Reset mid-operation with a strobe in the reset cycle
    cyc(0, 8'h00, 0, 1, 1, 1, 0, "pre_rst_err");
    chk("tp6 count5", 32'(fifo_count), 32'd5);
    rst_cyc(1'b1, 8'h77, "mid_reset");
    chk("tp6 count0", 32'(fifo_count), 32'd0);
    chk("tp6 overrun0", 32'(overrun), 32'd0);
    cyc(0, 8'h00, 1, 0, 0, 0, 0, "post_reset");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic v, r, fe, pe, se, cl;
      v  = ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 2) == 0);
      fe = ($urandom_range(0, 3) == 0);
      pe = $urandom_range(0, 1) == 1;
      se = $urandom_range(0, 1) == 1;
      cl = ($urandom_range(0, 40) == 0);
      cyc(v, 8'($urandom), r, fe, pe, se, cl, "random");
    end
    for (int i = 0; i < 10; i++) cyc(0, 8'h00, 1, 0, 0, 0, 0, "final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_out_fifo.md
Name: uart_rx_out_fifo

Overview:
- Downstream consumer of the UART receiver control FSM and deserializer.
- Captures each error-free received byte on the receiver's one-cycle data-valid strobe and buffers it in a small synchronous FIFO.
- Presents buffered bytes to the system side through a valid/ready handshake.
- Tracks overrun and receive-error status so software or upstream logic can tell when bytes were lost or frames were bad.

Parameters:
- DATA_WIDTH, 8, width of one received byte.
- FIFO_DEPTH, 8, number of entries; power of two, 2..64.
- CNT_WIDTH, $clog2(FIFO_DEPTH)+1, width of the occupancy count.

Ports:
- CLK  input  1  block clock; same domain as the receiver FSM.
- RST  input  1  reset, synchronous, active-low; sampled only on the rising edge of CLK.
- rx_p_data  input  DATA_WIDTH  parallel byte from the deserializer; stable while rx_data_valid is high.
- rx_data_valid  input  1  one-cycle strobe: frame completed with no parity or stop error.
- rx_frame_end  input  1  one-cycle strobe in the error-check cycle of every frame, good or bad.
- rx_par_err  input  1  parity error flag; qualified by rx_frame_end.
- rx_stp_err  input  1  stop-bit error flag; qualified by rx_frame_end.
- m_data  output  DATA_WIDTH  head-of-FIFO byte.
- m_valid  output  1  FIFO not empty.
- m_ready  input  1  consumer accepts m_data when m_valid && m_ready.
- fifo_count  output  CNT_WIDTH  current occupancy, 0..FIFO_DEPTH.
- fifo_full  output  1  fifo_count == FIFO_DEPTH.
- overrun  output  1  sticky: a byte was dropped.
- clr_status  input  1  one-cycle pulse; clears overrun and the error counters.
- par_err_cnt  output  8  saturating parity-error frame count.
- stp_err_cnt  output  8  saturating stop-error frame count.

Behaviour:
- Reset (RST low at a CLK edge):
  - Read/write pointers and count go to 0, so m_valid=0, fifo_count=0, fifo_full=0.
  - overrun=0, par_err_cnt=0, stp_err_cnt=0.
  - m_data=0 while empty. Memory contents are not reset.
- Reset mid-operation discards all buffered bytes. A strobe arriving in the reset cycle is ignored.
- Push request: rx_data_valid=1. Pop: m_valid && m_ready.
- Push acceptance:
  - Accepted if !fifo_full, or if fifo_full and a pop occurs in the same cycle (the slot is freed and reused).
  - Full with no pop: the byte is dropped, overrun is set the next cycle, and contents are unchanged.
- Latency:
  - A byte pushed into an empty FIFO appears on m_data with m_valid=1 the next cycle.
  - m_data is driven from the head entry and changes only after a pop or a first push.
- Simultaneous push and pop when not empty: count is unchanged and both pointers advance.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits wide and wrap naturally from FIFO_DEPTH-1 to 0.
- Output registers: fifo_count, fifo_full and m_valid are registered or derived only from registered state. There is no combinational path from rx_* to any output.
- m_ready with m_valid=0 has no effect.
- Precedence between clr_status and overrun:
  - clr_status and a new overrun in the same cycle: overrun ends at 1 (set wins).
  - clr_status with no new overrun: overrun goes to 0 the next cycle.
- rx_data_valid without rx_frame_end: still pushed, since upstream guarantees coincidence. Error counters look only at rx_frame_end.
- Error flags (rx_par_err, rx_stp_err) are ignored unless rx_frame_end=1.
- No state machine beyond the FIFO pointers. The block must tolerate back-to-back frames: one strobe per frame, never two in consecutive cycles in practice, but any rate is handled correctly.

Optional Feature:
- Macro: UART_RX_ERR_CNT_EN.
- When defined:
  - On rx_frame_end, par_err_cnt increments if rx_par_err=1, and stp_err_cnt increments if rx_stp_err=1. Both may increment in the same cycle.
  - Counters saturate at 255 and do not wrap.
  - clr_status clears both the next cycle; clear wins over a same-cycle increment.
- When undefined: par_err_cnt and stp_err_cnt are constant 0, no counter flops exist, and ports remain for a fixed interface.

Test Plan:
- Reset, then push 0xA5 with m_ready=0 -> next cycle m_valid=1, m_data=0xA5, fifo_count=1. Pull m_ready=1 for 1 cycle -> m_valid=0, fifo_count=0.
- Push 8 bytes 0x01..0x08 with m_ready=0 -> fifo_full=1, fifo_count=8. Push 0x09 -> overrun=1, count 8. Drain yields 0x01..0x08 in order. clr_status -> overrun=0.
- FIFO full, push 0x55 with m_ready=1 in the same cycle -> no overrun, count stays 8, last byte drained is 0x55.
- Steady push+pop every cycle for 20 bytes across pointer wrap -> output sequence matches input, count stays at 1.
- With UART_RX_ERR_CNT_EN: 3 frame_end with par_err, 2 with stp_err, 1 with both -> par_err_cnt=4, stp_err_cnt=3, no bytes pushed. 300 parity errors -> par_err_cnt=255.
- Hold FIFO at count 5, assert RST low for one CLK edge while rx_data_valid=1 -> count=0, m_valid=0, overrun=0, counters=0, strobe discarded.
